// File: rtl/axis_pkg.sv
// Shared stream-datapath types and constants used by the complex integer divider.
package axis_pkg;

  localparam int SAMPLE_INT_W = 16;
  // Width of a signed sum of two 16x16 signed products.
  localparam int CDIV_NUM_W   = 2 * SAMPLE_INT_W + 1;
  // Iteration counter width; holds up to 32 + 15 = 47.
  localparam int CDIV_CNT_W   = 6;

  typedef struct packed {
    logic signed [SAMPLE_INT_W-1:0] re;
    logic signed [SAMPLE_INT_W-1:0] im;
  } sample_t_int;

  typedef enum logic [1:0] {
    CDIV_IDLE = 2'd0,
    CDIV_MULT = 2'd1,
    CDIV_DIV  = 2'd2,
    CDIV_DONE = 2'd3
  } cdiv_state_e;

endpackage

// File: rtl/uint_restoring_div.sv
// Unsigned restoring divider, one quotient bit per step, MSB first.
// The start cycle loads the operands and already performs the first step,
// so a full division takes one start plus DIVIDEND_W-1 steps.
module uint_restoring_div #(
  parameter int DIVIDEND_W = 32,
  parameter int DIVISOR_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  step,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W:0]    remainder
);

  localparam int REM_W = DIVISOR_W + 1;

  logic [DIVIDEND_W-1:0]       q_r;
  logic [REM_W-1:0]            rem_r;
  logic [DIVISOR_W-1:0]        dsr_r;
  logic [REM_W+DIVIDEND_W-1:0] step_s;

  // One restoring iteration: shift in the next dividend bit, keep the
  // subtraction only if it does not go negative.
  function automatic logic [REM_W+DIVIDEND_W-1:0] restore_step(
    input logic [REM_W-1:0]      rem,
    input logic [DIVIDEND_W-1:0] q,
    input logic [DIVISOR_W-1:0]  dsr
  );
    logic [REM_W-1:0] shifted;
    logic [REM_W:0]   trial;
    shifted = {rem[REM_W-2:0], q[DIVIDEND_W-1]};
    trial   = {1'b0, shifted} - {2'b00, dsr};
    if (trial[REM_W]) begin
      restore_step = {shifted, q[DIVIDEND_W-2:0], 1'b0};
    end else begin
      restore_step = {trial[REM_W-1:0], q[DIVIDEND_W-2:0], 1'b1};
    end
  endfunction

  // Select the step inputs: fresh operands on start, running state otherwise.
  always_comb begin
    if (start) begin
      step_s = restore_step({REM_W{1'b0}}, dividend, divisor);
    end else begin
      step_s = restore_step(rem_r, q_r, dsr_r);
    end
  end

  // Quotient/remainder shift registers and latched divisor.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r   <= {DIVIDEND_W{1'b0}};
      rem_r <= {REM_W{1'b0}};
      dsr_r <= {DIVISOR_W{1'b0}};
    end else if (start) begin
      {rem_r, q_r} <= step_s;
      dsr_r        <= divisor;
    end else if (step) begin
      {rem_r, q_r} <= step_s;
    end
  end

  assign quotient  = q_r;
  assign remainder = rem_r;

endmodule

// File: rtl/complex_int_div.sv
// Iterative complex integer divider: z = a*conj(b) / |b|^2, with two
// restoring dividers working on numerator magnitudes in parallel.
module complex_int_div
  import axis_pkg::*;
#(
  parameter int FRAC_W = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  sample_t_int a,
  input  sample_t_int b,
  output logic        out_valid,
  input  logic        out_ready,
  output sample_t_int z,
  output logic        div_zero
);

  localparam int DEN_W  = 2 * SAMPLE_INT_W;
  localparam int MAG_W  = DEN_W + FRAC_W;
  localparam int N_ITER = DEN_W + FRAC_W;

  cdiv_state_e            state_r, next_state_s;
  logic                   in_ready_r, out_valid_r;
  sample_t_int            a_r, b_r, z_r;
  logic                   div_zero_r, den_zero_r, neg_re_r, neg_im_r;
  logic [CDIV_CNT_W-1:0]  cnt_r;
  logic                   load_s, div_start_s, div_step_s, capture_s, in_div_s;

  logic signed [DEN_W-1:0]      p_rr_s, p_ii_s, p_ir_s, p_ri_s, p_br_s, p_bi_s;
  logic signed [CDIV_NUM_W-1:0] num_re_s, num_im_s;
  logic [DEN_W-1:0]             den_s;
  logic [MAG_W-1:0]             dvd_re_s, dvd_im_s, q_re_s, q_im_s;
  logic [DEN_W:0]               rem_re_unused_s, rem_im_unused_s;

  // Magnitude of a signed numerator; fits DEN_W bits since |num| <= 2^31.
  function automatic logic [DEN_W-1:0] num_mag(input logic signed [CDIV_NUM_W-1:0] num);
    logic [CDIV_NUM_W-1:0] neg;
    neg = ~num + CDIV_NUM_W'(1);
    if (num[CDIV_NUM_W-1]) begin
      num_mag = neg[DEN_W-1:0];
    end else begin
      num_mag = num[DEN_W-1:0];
    end
  endfunction

  // Re-apply the sign to a quotient magnitude and clamp to 16-bit signed.
  function automatic logic signed [SAMPLE_INT_W-1:0] saturate(
    input logic             neg,
    input logic [MAG_W-1:0] mag
  );
    logic [MAG_W-1:0] neg_mag;
    neg_mag = ~mag + MAG_W'(1);
    if (neg) begin
      if (mag > MAG_W'(32768)) begin
        saturate = 16'sh8000;
      end else begin
        saturate = neg_mag[SAMPLE_INT_W-1:0];
      end
    end else begin
      if (mag > MAG_W'(32767)) begin
        saturate = 16'sh7FFF;
      end else begin
        saturate = mag[SAMPLE_INT_W-1:0];
      end
    end
  endfunction

  // State register; handshake flags are registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= CDIV_IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      in_ready_r  <= (next_state_s == CDIV_IDLE);
      out_valid_r <= (next_state_s == CDIV_DONE);
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      CDIV_IDLE: begin
        if (in_valid) next_state_s = CDIV_MULT;
        else          next_state_s = CDIV_IDLE;
      end
      CDIV_MULT: next_state_s = CDIV_DIV;
      CDIV_DIV: begin
        if (cnt_r == CDIV_CNT_W'(1)) next_state_s = CDIV_DONE;
        else                          next_state_s = CDIV_DIV;
      end
      CDIV_DONE: begin
        if (out_ready) next_state_s = CDIV_IDLE;
        else           next_state_s = CDIV_DONE;
      end
      default: next_state_s = CDIV_IDLE;
    endcase
  end

  // Datapath control strobes decoded from the current state.
  always_comb begin
    load_s      = 1'b0;
    div_start_s = 1'b0;
    div_step_s  = 1'b0;
    capture_s   = 1'b0;
    in_div_s    = 1'b0;
    case (state_r)
      CDIV_IDLE: load_s      = in_valid;
      CDIV_MULT: div_start_s = 1'b1;
      CDIV_DIV: begin
        in_div_s = 1'b1;
        if (cnt_r == CDIV_CNT_W'(1)) capture_s  = 1'b1;
        else                          div_step_s = 1'b1;
      end
      CDIV_DONE: load_s = 1'b0;
      default:   load_s = 1'b0;
    endcase
  end

  // Multiply stage: numerators of a*conj(b), denominator |b|^2, shifted magnitudes.
  always_comb begin
    p_rr_s   = a_r.re * b_r.re;
    p_ii_s   = a_r.im * b_r.im;
    p_ir_s   = a_r.im * b_r.re;
    p_ri_s   = a_r.re * b_r.im;
    p_br_s   = b_r.re * b_r.re;
    p_bi_s   = b_r.im * b_r.im;
    num_re_s = {p_rr_s[DEN_W-1], p_rr_s} + {p_ii_s[DEN_W-1], p_ii_s};
    num_im_s = {p_ir_s[DEN_W-1], p_ir_s} - {p_ri_s[DEN_W-1], p_ri_s};
    den_s    = $unsigned(p_br_s) + $unsigned(p_bi_s);
    dvd_re_s = MAG_W'(num_mag(num_re_s)) << FRAC_W;
    dvd_im_s = MAG_W'(num_mag(num_im_s)) << FRAC_W;
  end

  uint_restoring_div #(.DIVIDEND_W(MAG_W), .DIVISOR_W(DEN_W)) u_div_re (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start_s),
    .step      (div_step_s),
    .dividend  (dvd_re_s),
    .divisor   (den_s),
    .quotient  (q_re_s),
    .remainder (rem_re_unused_s)
  );

  uint_restoring_div #(.DIVIDEND_W(MAG_W), .DIVISOR_W(DEN_W)) u_div_im (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start_s),
    .step      (div_step_s),
    .dividend  (dvd_im_s),
    .divisor   (den_s),
    .quotient  (q_im_s),
    .remainder (rem_im_unused_s)
  );

  // Operand capture, sign/zero tracking, iteration counter and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r        <= '0;
      b_r        <= '0;
      z_r        <= '0;
      div_zero_r <= 1'b0;
      den_zero_r <= 1'b0;
      neg_re_r   <= 1'b0;
      neg_im_r   <= 1'b0;
      cnt_r      <= {CDIV_CNT_W{1'b0}};
    end else begin
      if (load_s) begin
        a_r <= a;
        b_r <= b;
      end
      if (div_start_s) begin
        neg_re_r   <= num_re_s[CDIV_NUM_W-1];
        neg_im_r   <= num_im_s[CDIV_NUM_W-1];
        den_zero_r <= (den_s == {DEN_W{1'b0}});
        cnt_r      <= CDIV_CNT_W'(N_ITER);
      end else if (in_div_s) begin
        cnt_r <= cnt_r - CDIV_CNT_W'(1);
      end
      if (capture_s) begin
        if (den_zero_r) begin
          z_r        <= '0;
          div_zero_r <= 1'b1;
        end else begin
          z_r.re     <= saturate(neg_re_r, q_re_s);
          z_r.im     <= saturate(neg_im_r, q_im_s);
          div_zero_r <= 1'b0;
        end
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign z         = z_r;
  assign div_zero  = div_zero_r;

endmodule

// File: tb/tb_complex_int_div.sv
// Directed self-checking bench for complex_int_div (FRAC_W = 0 and 8 instances).
module tb_complex_int_div;
  import axis_pkg::*;

  logic        clk, rst;
  logic        iv0, iv8, ord0, ord8;
  logic        ir0, ir8, ov0, ov8, dz0, dz8;
  sample_t_int a, b, z0, z8;
  int          checks, errors;

  complex_int_div #(.FRAC_W(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .a(a), .b(b),
    .out_valid(ov0), .out_ready(ord0), .z(z0), .div_zero(dz0)
  );

  complex_int_div #(.FRAC_W(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a), .b(b),
    .out_valid(ov8), .out_ready(ord8), .z(z8), .div_zero(dz8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation and return cycles from input handshake to out_valid.
  task automatic do_op(input int sel, input logic signed [15:0] ar, input logic signed [15:0] ai,
                       input logic signed [15:0] br, input logic signed [15:0] bi, output int lat);
    int guard;
    a.re = ar; a.im = ai; b.re = br; b.im = bi;
    guard = 0;
    while (!((sel == 0) ? ir0 : ir8) && guard < 100) begin
      tick();
      guard++;
    end
    if (sel == 0) iv0 = 1'b1; else iv8 = 1'b1;
    tick();
    iv0 = 1'b0; iv8 = 1'b0;
    lat = 1;
    while (!((sel == 0) ? ov0 : ov8) && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  task automatic consume(input int sel);
    if (sel == 0) ord0 = 1'b1; else ord8 = 1'b1;
    tick();
    ord0 = 1'b0; ord8 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    checks++; if (ir0 !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b expected 1", ir0); end
    checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b expected 0", ov0); end
    checks++; if (z0 !== 32'h0) begin errors++; $display("FAIL reset_z got %h expected 0", z0); end
    checks++; if (dz0 !== 1'b0) begin errors++; $display("FAIL reset_div_zero got %b expected 0", dz0); end
    checks++; if (ir8 !== 1'b1) begin errors++; $display("FAIL reset_in_ready8 got %b expected 1", ir8); end
  endtask

  task automatic test_frac0();
    int lat;
    do_op(0, 16'sd3, 16'sd4, 16'sd1, 16'sd2, lat);
    checks++; if (lat !== 34) begin errors++; $display("FAIL frac0_latency got %0d expected 34", lat); end
    checks++; if (z0.re !== 16'sd2) begin errors++; $display("FAIL frac0_re got %0d expected 2", z0.re); end
    checks++; if (z0.im !== 16'sd0) begin errors++; $display("FAIL frac0_im got %0d expected 0", z0.im); end
    checks++; if (dz0 !== 1'b0) begin errors++; $display("FAIL frac0_div_zero got %b expected 0", dz0); end
    consume(0);
  endtask

  task automatic test_frac8();
    int lat;
    do_op(8, 16'sd3, 16'sd4, 16'sd1, 16'sd2, lat);
    checks++; if (lat !== 42) begin errors++; $display("FAIL frac8_latency got %0d expected 42", lat); end
    checks++; if (z8.re !== 16'sd563) begin errors++; $display("FAIL frac8_re got %0d expected 563", z8.re); end
    checks++; if (z8.im !== -16'sd102) begin errors++; $display("FAIL frac8_im got %0d expected -102", z8.im); end
    consume(8);
  endtask

  task automatic test_saturation();
    int lat;
    do_op(8, 16'sd1000, 16'sd0, 16'sd1, 16'sd0, lat);
    checks++; if (z8.re !== 16'sd32767) begin errors++; $display("FAIL sat_pos_re got %0d expected 32767", z8.re); end
    checks++; if (z8.im !== 16'sd0) begin errors++; $display("FAIL sat_pos_im got %0d expected 0", z8.im); end
    consume(8);
    do_op(8, -16'sd1000, 16'sd0, 16'sd1, 16'sd0, lat);
    checks++; if (z8.re !== -16'sd32768) begin errors++; $display("FAIL sat_neg_re got %0d expected -32768", z8.re); end
    checks++; if (z8.im !== 16'sd0) begin errors++; $display("FAIL sat_neg_im got %0d expected 0", z8.im); end
    consume(8);
  endtask

  task automatic test_div_zero();
    int lat;
    do_op(0, 16'sd5, 16'sd5, 16'sd0, 16'sd0, lat);
    checks++; if (lat !== 34) begin errors++; $display("FAIL dz_latency got %0d expected 34", lat); end
    checks++; if (z0 !== 32'h0) begin errors++; $display("FAIL dz_z got %h expected 0", z0); end
    checks++; if (dz0 !== 1'b1) begin errors++; $display("FAIL dz_flag got %b expected 1", dz0); end
    consume(0);
  endtask

  task automatic test_backpressure();
    int guard;
    a.re = 16'sd3; a.im = 16'sd4; b.re = 16'sd1; b.im = 16'sd2;
    iv0 = 1'b1;
    tick();
    iv0 = 1'b0;
    repeat (5) tick();
    a.re = 16'sd7; a.im = 16'sd7; b.re = 16'sd1; b.im = 16'sd0;
    iv0 = 1'b1;
    tick();
    checks++; if (ir0 !== 1'b0) begin errors++; $display("FAIL bp_busy_in_ready got %b expected 0", ir0); end
    iv0 = 1'b0;
    guard = 0;
    while (!ov0 && guard < 100) begin tick(); guard++; end
    checks++; if (ov0 !== 1'b1) begin errors++; $display("FAIL bp_out_valid_timeout got %b expected 1", ov0); end
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++; if (ov0 !== 1'b1) begin errors++; $display("FAIL bp_hold_valid cycle %0d got %b expected 1", i, ov0); end
      checks++; if (ir0 !== 1'b0) begin errors++; $display("FAIL bp_hold_in_ready cycle %0d got %b expected 0", i, ir0); end
      checks++; if (z0.re !== 16'sd2 || z0.im !== 16'sd0) begin
        errors++; $display("FAIL bp_hold_z cycle %0d got (%0d,%0d) expected (2,0)", i, z0.re, z0.im);
      end
    end
    checks++; if (dz0 !== 1'b0) begin errors++; $display("FAIL bp_div_zero got %b expected 0", dz0); end
    consume(0);
    checks++; if (ir0 !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready got %b expected 1", ir0); end
    checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL bp_release_out_valid got %b expected 0", ov0); end
    checks++; if (z0.re !== 16'sd2) begin errors++; $display("FAIL bp_after_z got %0d expected 2", z0.re); end
  endtask

  task automatic test_back_to_back();
    int first, second, ovc, guard;
    first = -1; second = -1; ovc = 0;
    a.re = 16'sd3; a.im = 16'sd4; b.re = 16'sd1; b.im = 16'sd2;
    iv0 = 1'b1; ord0 = 1'b1;
    for (int c = 0; c < 120 && second < 0; c++) begin
      if (ir0) begin
        if (first < 0) first = c; else second = c;
      end
      if (first >= 0 && second < 0 && ov0) ovc++;
      tick();
    end
    iv0 = 1'b0;
    checks++; if (second - first !== 35) begin errors++; $display("FAIL b2b_period got %0d expected 35", second - first); end
    checks++; if (ovc !== 1) begin errors++; $display("FAIL b2b_valid_cycles got %0d expected 1", ovc); end
    guard = 0;
    while (!ir0 && guard < 100) begin tick(); guard++; end
    ord0 = 1'b0;
    checks++; if (z0.re !== 16'sd2) begin errors++; $display("FAIL b2b_z got %0d expected 2", z0.re); end
  endtask

  task automatic test_reset_mid();
    int lat;
    a.re = 16'sd3; a.im = 16'sd4; b.re = 16'sd1; b.im = 16'sd2;
    iv0 = 1'b1;
    tick();
    iv0 = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL rmid_out_valid got %b expected 0", ov0); end
    checks++; if (ir0 !== 1'b1) begin errors++; $display("FAIL rmid_in_ready got %b expected 1", ir0); end
    checks++; if (z0 !== 32'h0) begin errors++; $display("FAIL rmid_z got %h expected 0", z0); end
    do_op(0, 16'sd3, 16'sd4, 16'sd1, 16'sd2, lat);
    checks++; if (lat !== 34) begin errors++; $display("FAIL rmid_latency got %0d expected 34", lat); end
    checks++; if (z0.re !== 16'sd2 || z0.im !== 16'sd0) begin
      errors++; $display("FAIL rmid_z_after got (%0d,%0d) expected (2,0)", z0.re, z0.im);
    end
    consume(0);
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; iv0 = 1'b0; iv8 = 1'b0; ord0 = 1'b0; ord8 = 1'b0;
    a = '0; b = '0;
    test_reset();
    test_frac0();
    test_frac8();
    test_saturation();
    test_div_zero();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
